// File: rtl/wb_burst_sequencer_if.sv
// Wishbone B4 master-side bus bundle for the burst sequencer and its slave interconnect.
// stb is one strobe bit per slave; dat_w carries write data, dat_r the muxed slave read data.
interface wb_burst_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic                  cyc;
  logic                  we;
  logic [NUM_SLAVES-1:0] stb;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [SEL_WIDTH-1:0]  sel;
  logic [2:0]            cti;
  logic [1:0]            bte;
  logic                  ack;
  logic                  err;
  logic [DATA_WIDTH-1:0] dat_r;

  modport master (
    output cyc, we, stb, adr, dat_w, sel, cti, bte,
    input  ack, err, dat_r
  );

  modport slave (
    input  cyc, we, stb, adr, dat_w, sel, cti, bte,
    output ack, err, dat_r
  );
endinterface

// File: rtl/wb_burst_sequencer.sv
// Wishbone B4 burst master: accepts one request, runs a classic or incrementing burst to
// the addressed slave and terminates on last ack, err, timeout or an illegal request.
module wb_burst_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int NUM_SLAVES = 2,
  parameter int MAX_BEATS  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [ADDR_WIDTH-1:0]        req_addr_i,
  input  logic [$clog2(MAX_BEATS)-1:0] req_len_i,
  input  logic [SEL_WIDTH-1:0]         req_sel_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  output logic                         wr_pop_o,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic                         rd_valid_o,
  output logic                         done_o,
  output logic                         err_o,
  wb_burst_sequencer_if.master         wb
);
  localparam int LEN_W  = $clog2(MAX_BEATS);
  localparam int REGION = (2 ** ADDR_WIDTH) / NUM_SLAVES;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [NUM_SLAVES-1:0] stb_q, stb_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Request legality: the whole burst must stay inside one slave region without wrapping.
  logic [ADDR_WIDTH:0]   end_addr;
  logic [ADDR_WIDTH:0]   start_region;
  logic [ADDR_WIDTH:0]   end_region;
  logic                  reject;
  logic [NUM_SLAVES-1:0] req_stb;

  assign end_addr     = {1'b0, req_addr_i} + (ADDR_WIDTH+1)'(req_len_i);
  assign start_region = {1'b0, req_addr_i} / (ADDR_WIDTH+1)'(REGION);
  assign end_region   = {1'b0, end_addr[ADDR_WIDTH-1:0]} / (ADDR_WIDTH+1)'(REGION);
  assign reject       = end_addr[ADDR_WIDTH] | (start_region != end_region);

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_stb_decode
      assign req_stb[gi] = (start_region == (ADDR_WIDTH+1)'(gi));
    end
  endgenerate

  logic active;
  logic beat_ack;
  logic last_beat;
  logic tmo_hit;

  assign active    = (state_q == ACTIVE);
  assign beat_ack  = wb.ack & ~wb.err;
  assign last_beat = (cnt_q == len_q);
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    sel_d      = sel_q;
    stb_d      = stb_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          sel_d   = req_sel_i;
          len_d   = req_len_i;
          adr_d   = req_addr_i;
          cnt_d   = '0;
          tmo_d   = '0;
          stb_d   = req_stb;
          err_d   = reject;
          state_d = reject ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        // err terminates even when the slave also raised ack in the same cycle
        if (wb.err) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (wb.ack) begin
          adr_d = adr_q + ADDR_WIDTH'(1);
          cnt_d = cnt_q + LEN_W'(1);
          tmo_d = '0;
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = wb.dat_r;
          end
          if (last_beat) begin
            state_d = DONE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      stb_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      stb_q      <= stb_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Bus outputs are gated by the state register so an async reset clears them at once.
  assign wb.cyc   = active;
  assign wb.stb   = active ? stb_q : '0;
  assign wb.we    = active & we_q;
  assign wb.adr   = active ? adr_q : '0;
  assign wb.sel   = active ? sel_q : '0;
  assign wb.dat_w = (active && we_q) ? wr_data_i : '0;
  assign wb.cti   = !active          ? 3'b000 :
                    (len_q == '0)    ? 3'b000 :
                    last_beat        ? 3'b111 : 3'b010;
  assign wb.bte   = 2'b00;

  assign req_ready_o = (state_q == IDLE);
  assign wr_pop_o    = active & we_q & beat_ack;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == DONE) & err_q;
endmodule

// File: tb/tb_wb_burst_sequencer.sv
// Scoreboard bench: a burst-level model queues expected beats/reads/done per request,
// and a combined slave+monitor process pops and compares as the DUT produces them.
module tb_wb_burst_sequencer;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int NS = 2;
  localparam int MB = 8;
  localparam int TO = 16;

  localparam int EV_BEAT = 0;
  localparam int EV_RD   = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int           kind;
    logic [AW-1:0] adr;
    logic [NS-1:0] stb;
    logic [2:0]    cti;
    logic          we;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          err;
    logic          cyc;
    logic          tmo;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_len;
  logic [SW-1:0] req_sel;
  logic [DW-1:0] wr_data;
  logic          wr_pop;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          err;

  wb_burst_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) wb ();

  wb_burst_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
    .NUM_SLAVES(NS), .MAX_BEATS(MB), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_len_i(req_len), .req_sel_i(req_sel),
    .wr_data_i(wr_data), .wr_pop_o(wr_pop),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .done_o(done), .err_o(err),
    .wb(wb)
  );

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic [DW-1:0] mem [16];
  logic [DW-1:0] wdata [9];
  int  wptr;
  int  plan_abort = -1;
  bit  plan_stall = 1'b0;
  bit  plan_ackall = 1'b0;
  int  done_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Source FIFO head: advances on every pop, rewinds whenever the bus is idle.
  always @(posedge clk or negedge rst_i) begin
    if (!rst_i)         wptr <= 0;
    else if (!wb.cyc)   wptr <= 0;
    else if (wr_pop)    wptr <= wptr + 1;
  end
  assign wr_data = (wptr < 9) ? wdata[wptr] : '0;

  // Slave model + monitor
  int   sl_beat = 0, gap = 0, idle_run = 0, cyc_n = 0, last_term = 0;
  bit   prev_cyc = 1'b0, had_cyc = 1'b0;
  logic ack_v, err_v;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_i) begin
      wb.ack = 1'b0; wb.err = 1'b0; wb.dat_r = '0;
      sl_beat = 0; prev_cyc = 1'b0; had_cyc = 1'b0;
    end else begin
      cyc_n++;
      if (rd_valid) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rd_kind", e.kind, EV_RD);
          chk("rd_data", rd_data, e.dat);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("done_kind", e.kind, EV_DONE);
          chk("done_err", err, e.err);
          chk("done_had_cyc", had_cyc, e.cyc);
          chk("done_ready_low", req_ready, 0);
          chk("done_cyc_low", wb.cyc, 0);
          if (e.tmo) chk("timeout_cycles", idle_run, TO);
          else if (e.cyc) chk("done_latency", cyc_n - last_term, 1);
        end
        had_cyc = 1'b0;
        done_cnt++;
      end
      if (wb.cyc) begin
        if (!prev_cyc) begin sl_beat = 0; gap = 0; idle_run = 0; end
        had_cyc = 1'b1;
        ack_v = 1'b0; err_v = 1'b0;
        if (plan_abort == sl_beat) begin
          if (!plan_stall) begin err_v = 1'b1; ack_v = 1'($urandom_range(0, 1)); end
        end else if (plan_ackall || gap >= 2 || $urandom_range(0, 3) != 0) begin
          ack_v = 1'b1;
        end
        wb.ack = ack_v; wb.err = err_v;
        wb.dat_r = ack_v ? mem[wb.adr] : $urandom;
        #1;
        if (ack_v && !err_v) begin
          if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("beat_kind", e.kind, EV_BEAT);
            chk("beat_adr", wb.adr, e.adr);
            chk("beat_stb", wb.stb, e.stb);
            chk("beat_cti", wb.cti, e.cti);
            chk("beat_we", wb.we, e.we);
            chk("beat_sel", wb.sel, e.sel);
            chk("beat_dat", wb.dat_w, e.dat);
            chk("beat_pop", wr_pop, e.we);
            chk("beat_bte", wb.bte, 0);
          end
          sl_beat++; gap = 0; idle_run = 0; last_term = cyc_n;
        end else if (err_v) begin
          chk("err_no_pop", wr_pop, 0);
          gap = 0; idle_run = 0; last_term = cyc_n;
        end else begin
          gap++; idle_run++;
        end
      end else begin
        wb.ack = 1'b0; wb.err = 1'b0;
      end
      prev_cyc = wb.cyc;
    end
  end

  // Burst-level reference: legality, beats completed before any abort, and final status.
  task automatic push_model(input bit we, input logic [AW-1:0] addr, input logic [2:0] len,
                            input logic [SW-1:0] sel, input int abort, input bit stall);
    int   last = int'(addr) + int'(len);
    int   n_ok;
    exp_t x;
    x = '{kind: EV_DONE, adr: '0, stb: '0, cti: '0, we: 1'b0, dat: '0, sel: '0,
          err: 1'b1, cyc: 1'b0, tmo: 1'b0};
    if (last > 15 || (int'(addr) / 8) != (last / 8)) begin
      exp_q.push_back(x);
      plan_abort = -1;
      return;
    end
    n_ok = (abort >= 0) ? abort : int'(len) + 1;
    for (int i = 0; i < n_ok; i++) begin
      x.kind = EV_BEAT;
      x.adr  = AW'(int'(addr) + i);
      x.stb  = (addr < 8) ? 2'b01 : 2'b10;
      x.cti  = (len == 0) ? 3'b000 : ((i == int'(len)) ? 3'b111 : 3'b010);
      x.we   = we;
      x.dat  = we ? wdata[i] : '0;
      x.sel  = sel;
      exp_q.push_back(x);
      if (!we) begin
        x.kind = EV_RD;
        x.dat  = mem[int'(addr) + i];
        exp_q.push_back(x);
      end
    end
    x.kind = EV_DONE; x.err = (abort >= 0); x.cyc = 1'b1; x.tmo = (abort >= 0) && stall;
    exp_q.push_back(x);
    plan_abort = abort;
    plan_stall = stall;
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [2:0] len,
                       input logic [SW-1:0] sel, output bit ok);
    int k = 0;
    req_we = we; req_addr = addr; req_len = len; req_sel = sel; req_valid = 1'b1;
    while (!req_ready && k < 50) begin @(negedge clk); #2; k++; end
    ok = req_ready;
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_burst(input bit we, input logic [AW-1:0] addr, input logic [2:0] len,
                           input logic [SW-1:0] sel, input int abort, input bit stall);
    bit ok;
    int start = done_cnt;
    int k = 0;
    push_model(we, addr, len, sel, abort, stall);
    issue(we, addr, len, sel, ok);
    if (!ok) return;
    while (done_cnt == start && k < 100) begin @(negedge clk); #2; k++; end
    if (done_cnt == start) chk("done_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    rst_i = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0; req_sel = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int i = 0; i < 9; i++) wdata[i] = '0;
    #2;
    chk("rst_ready", req_ready, 1);
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_stb", wb.stb, 0);
    chk("rst_adr", wb.adr, 0);
    chk("rst_cti", wb.cti, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_pop", wr_pop, 0);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk); #2;

    // Directed scenarios
    wdata[0] = 32'h1111; wdata[1] = 32'h2222; wdata[2] = 32'h3333; wdata[3] = 32'h4444;
    plan_ackall = 1'b1;
    run_burst(1'b1, 4'h0, 3'd3, 4'hF, -1, 1'b0);
    run_burst(1'b0, 4'h9, 3'd0, 4'hF, -1, 1'b0);
    run_burst(1'b1, 4'h6, 3'd3, 4'hF, -1, 1'b0);
    plan_ackall = 1'b0;
    run_burst(1'b0, 4'h2, 3'd2, 4'h3, 1, 1'b0);
    run_burst(1'b0, 4'h3, 3'd1, 4'hC, 0, 1'b1);
    run_burst(1'b1, 4'hC, 3'd3, 4'h5, -1, 1'b0);

    // Reset during beat 2 of a 4-beat write
    plan_ackall = 1'b1;
    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    push_model(1'b1, 4'h8, 3'd3, 4'hF, -1, 1'b0);
    issue(1'b1, 4'h8, 3'd3, 4'hF, ok);
    if (ok) begin
      repeat (3) @(negedge clk);
      #2 rst_i = 1'b0;
      #1;
      chk("midrst_cyc", wb.cyc, 0);
      chk("midrst_stb", wb.stb, 0);
      chk("midrst_adr", wb.adr, 0);
      chk("midrst_we", wb.we, 0);
      chk("midrst_pop", wr_pop, 0);
      chk("midrst_done", done, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      #1 chk("midrst_ready_after", req_ready, 1);
      repeat (3) @(negedge clk);
      #2;
    end
    plan_ackall = 1'b0;

    // Randomized bursts
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      logic [2:0]    l;
      int            r, ab;
      bit            st, w;
      w  = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 15));
      l  = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      ab = -1; st = 1'b0;
      if (r < 2) ab = $urandom_range(0, int'(l));
      else if (r == 2) begin ab = $urandom_range(0, int'(l)); st = 1'b1; end
      for (int i = 0; i < 9; i++) wdata[i] = $urandom;
      run_burst(w, a, l, SW'($urandom_range(1, 15)), ab, st);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
